bidir_bus_port: RTL

Parametrised half-duplex bidirectional bus port for the USB research datapath. It owns one tri-state data bus (`data_io`) shared with a remote device and arbitrates direction with a turnaround state machine, so the two sides never drive the bus in the same cycle. The TX side takes beats through a valid/ready handshake and qualifies them to the remote with a strobe. The RX side captures strobed beats into a small first-word-fall-through FIFO. The block replaces the fixed 8-bit, externally steered port with registered output-enable control and guard cycles.

---
 rtl/bidir_bus_pkg.sv | 16 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/bidir_bus_port.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bidir_bus_pkg.sv
// Shared types for the half-duplex bidirectional bus port.
// Turnaround FSM states and counter sizing.
package bidir_bus_pkg;

  typedef enum logic [1:0] {
    ST_RX,
    ST_TA_TX,
    ST_TX,
    ST_TA_RX
  } state_t;

  function automatic int ta_cnt_w(input int ta);
    return (ta < 1) ? 1 : $clog2(ta + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Pop-before-push lets a full FIFO accept a beat on a popping edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/bidir_bus_port.sv
// Half-duplex tri-state bus port with turnaround FSM,
// TX valid/ready handshake and RX FWFT capture FIFO.
module bidir_bus_port
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int TA_CYCLES = 1,
  parameter int RX_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  inout  wire [WIDTH-1:0]  data_io,
  output logic             bus_oe_o,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  input  logic             tx_last_i,
  output logic             tx_ready_o,
  output logic             tx_stb_o,
  input  logic             rx_stb_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             rx_ovf_o,
  input  logic             ovf_clr_i,
  output logic             busy_o
);

  localparam int CW = ta_cnt_w(TA_CYCLES);
  localparam logic [CW-1:0] TA_LOAD =
    CW'(TA_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_n;
  logic [WIDTH-1:0] tx_q;
  logic             oe_q;
  logic             last_q;
  logic             stb_q;
  logic             ovf_q;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;

  assign tx_ready_o = (state == ST_TX) && !last_q;
  assign accept     = tx_valid_i && tx_ready_o;

  // Capture only while the bus is released and owned by the remote.
  assign push       = (state == ST_RX) && rx_stb_i;
  assign rx_valid_o = !empty;
  assign pop        = rx_valid_o && rx_ready_i;
  assign drop       = push && full && !pop;

  assign bus_oe_o = oe_q;
  assign tx_stb_o = stb_q;
  assign rx_ovf_o = ovf_q;
  assign busy_o   = (state != ST_RX);

  assign data_io = oe_q ? tx_q : 'z;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      ST_RX: begin
        if (tx_valid_i) begin
          state_n = ST_TA_TX;
          cnt_n   = TA_LOAD;
        end
      end
      ST_TA_TX: begin
        if (cnt == '0) state_n = ST_TX;
        else           cnt_n   = cnt - 1'b1;
      end
      ST_TX: begin
        if (last_q) begin
          state_n = ST_TA_RX;
          cnt_n   = TA_LOAD;
        end
      end
      ST_TA_RX: begin
        if (cnt == '0) state_n = ST_RX;
        else           cnt_n   = cnt - 1'b1;
      end
      default: state_n = ST_RX;
    endcase
  end

  // oe_q follows the next state so the bus is driven from the TX entry edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_RX;
      cnt    <= '0;
      oe_q   <= 1'b0;
      tx_q   <= '0;
      stb_q  <= 1'b0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      oe_q  <= (state_n == ST_TX);
      stb_q <= accept;
      if (accept) begin
        tx_q   <= tx_data_i;
        last_q <= tx_last_i;
      end else if (state == ST_TA_RX &&
                   state_n == ST_RX) begin
        last_q <= 1'b0;
      end
      if (drop)           ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (data_io),
    .pop   (pop),
    .rdata (rx_data_o),
    .full  (full),
    .empty (empty)
  );

endmodule
